onoff_ctrl: RTL
===============

ONOFF_CTRL -- requirements
Module: onoff_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 8, WAIT-state cycles allowed for fb to match target; legal range 2..255.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_on  input  1  requested target level (1 = on, 0 = off).
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 fb  input  1  observed output of the controlled two-state on/off machine.
REQ-008 j  output  1  set pulse to controlled machine.
REQ-009 k  output  1  clear pulse to controlled machine.
REQ-010 busy  output  1  request in progress.
REQ-011 done  output  1  one-cycle pulse, target reached.
REQ-012 err  output  1  one-cycle pulse, target not reached within timeout.

Function
REQ-013 States: IDLE, DRIVE, WAIT, DONE, ERR; all outputs are Moore decodes of state plus latched target.
REQ-014 req_ready = 1 only in IDLE; busy = 1 in DRIVE and WAIT only.
REQ-015 Accept occurs on a clock edge with req_valid=1 and req_ready=1; req_on is latched as target at accept.
REQ-016 req_valid outside IDLE is ignored; no queuing.
REQ-017 IDLE->DONE on accept when fb equals req_on (no j/k pulse issued).
REQ-018 IDLE->DRIVE on accept when fb differs from req_on.
REQ-019 DRIVE lasts exactly one cycle: j = target, k = ~target; never j=1 and k=1 together; then ->WAIT with timeout counter cleared.
REQ-020 j and k are 0 in every state other than DRIVE.
REQ-021 WAIT: fb equal to target -> DONE; otherwise counter increments; a mismatch in the cycle where counter = TIMEOUT-1 -> ERR.
REQ-022 DONE asserts done for one cycle, ERR asserts err for one cycle; both return to IDLE next cycle; done and err never both 1.
REQ-023 Latency, mismatched accept at edge N: j/k high cycle N+1, done high cycle N+3 when fb follows one cycle after the pulse.
REQ-024 Latency, matched accept at edge N: done high cycle N+1.
REQ-025 fb toggling away from target after a match has no effect on the current transaction.
REQ-026 Counter width holds TIMEOUT-1 without wrap; counter never wraps.

Reset
REQ-027 reset low forces IDLE immediately, independent of clk.
REQ-028 During and after reset: j=0, k=0, done=0, err=0, busy=0, req_ready=1, target=0, counter=0.
REQ-029 Reset mid-transaction abandons it; no done or err pulse is produced for it.

Configuration
REQ-030 Macro ONOFF_CTRL_RETRY_EN defined: first timeout in WAIT returns to DRIVE (second j/k pulse, counter cleared), second timeout -> ERR; retry flag cleared at accept and reset.
REQ-031 Macro ONOFF_CTRL_RETRY_EN undefined: first timeout -> ERR; no retry logic present.

Verification
REQ-032 fb=0, req_on=1 accepted at edge N, fb rises at N+2 -> j=1 cycle N+1 only, done=1 cycle N+3, err=0.
REQ-033 fb=1, req_on=1 accepted -> no j/k pulse, done=1 next cycle, req_ready=1 the cycle after.
REQ-034 fb held 0, req_on=1, TIMEOUT=8, macro off -> single j pulse, err=1 exactly 8 WAIT cycles later, done never 1.
REQ-035 Same as REQ-034 with ONOFF_CTRL_RETRY_EN -> two j pulses separated by 9 cycles, err=1 once after second timeout.
REQ-036 reset low asynchronously during WAIT -> outputs at reset values immediately, no done/err; new req_on=0 with fb=1 afterwards -> k=1 one cycle, j=0.

Source files
------------

// File: rtl/onoff_ctrl.sv
// onoff_ctrl: request/acknowledge controller for a two-state on/off machine.
// It issues a one-cycle j (set) or k (clear) pulse, then waits for the
// feedback to reach the requested level. If fb does not match within
// TIMEOUT WAIT cycles, the controller reports err.
// Optional build macro: ONOFF_CTRL_RETRY_EN. When it is defined, the first
// timeout re-issues the drive pulse once, and only the second timeout
// reports err.
module onoff_ctrl #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_on,
  output logic req_ready,
  input  logic fb,
  output logic j,
  output logic k,
  output logic busy,
  output logic done,
  output logic err
);

  // Just wide enough to hold TIMEOUT-1, so the counter never needs to wrap.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic          target_reg, target_next;
  logic [CW-1:0] count_reg, count_next;
`ifdef ONOFF_CTRL_RETRY_EN
  logic          retry_reg, retry_next;
`endif

  // State register; reset abandons any transaction in flight immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      target_reg <= 1'b0;
      count_reg  <= '0;
`ifdef ONOFF_CTRL_RETRY_EN
      retry_reg  <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      count_reg  <= count_next;
`ifdef ONOFF_CTRL_RETRY_EN
      retry_reg  <= retry_next;
`endif
    end
  end

  // Next-state logic: accept, drive, wait for fb, then report.
  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    count_next  = count_reg;
`ifdef ONOFF_CTRL_RETRY_EN
    retry_next  = retry_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (req_valid) begin
          target_next = req_on;
`ifdef ONOFF_CTRL_RETRY_EN
          retry_next  = 1'b0;
`endif
          // If the machine is already at the requested level, no pulse is needed.
          state_next  = (fb == req_on) ? DONE : DRIVE;
        end
      end
      DRIVE: begin
        count_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (fb == target_reg) begin
          state_next = DONE;
        end else if (count_reg == COUNT_LAST) begin
`ifdef ONOFF_CTRL_RETRY_EN
          if (!retry_reg) begin
            retry_next = 1'b1;
            state_next = DRIVE;
          end else begin
            state_next = ERR;
          end
`else
          state_next = ERR;
`endif
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore output decode from the state and the latched target.
  always_comb begin
    req_ready = (state_reg == IDLE);
    busy      = (state_reg == DRIVE) || (state_reg == WAIT);
    j         = (state_reg == DRIVE) &&  target_reg;
    k         = (state_reg == DRIVE) && !target_reg;
    done      = (state_reg == DONE);
    err       = (state_reg == ERR);
  end

endmodule
